// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and data-memory port bundle for mem_access_unit
interface mem_access_unit_if #(
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W+2:0] req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic [63:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_WE;
    logic [63:0]       mem_dIn;
    logic [63:0]       mem_dout;

    // master: core datapath plus data memory; slave: the access unit
    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_WE, mem_dIn
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_WE, mem_dIn
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RISC-V load/store unit for a 64-bit-word data memory
module mem_access_unit #(
    parameter int ADDR_W   = 5,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.slave   bus
);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t            state, state_nxt;

    logic              we_q, we_nxt;
    logic [1:0]        size_q, size_nxt;
    logic              uns_q, uns_nxt;
    logic [2:0]        off_q, off_nxt;
    logic [63:0]       wdata_q, wdata_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;

    logic              ready_q, ready_nxt;
    logic              rv_q, rv_nxt;
    logic [63:0]       rdata_q, rdata_nxt;
    logic              err_q, err_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic              mwe_q, mwe_nxt;
    logic [63:0]       din_q, din_nxt;

    logic              accept;
    logic              misaligned;
    logic [5:0]        shamt;
    logic [63:0]       lane_mask;
    logic [63:0]       merged;
    logic [63:0]       shifted;
    logic [63:0]       extended;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 64'h0000_0000_0000_00FF;
            2'b01:   return 64'h0000_0000_0000_FFFF;
            2'b10:   return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] w, input logic [1:0] sz,
                                           input logic uns);
        case (sz)
            2'b00:   return uns ? {56'd0, w[7:0]}  : {{56{w[7]}},  w[7:0]};
            2'b01:   return uns ? {48'd0, w[15:0]} : {{48{w[15]}}, w[15:0]};
            2'b10:   return uns ? {32'd0, w[31:0]} : {{32{w[31]}}, w[31:0]};
            default: return w;
        endcase
    endfunction

    assign accept = bus.req_valid && ready_q;

    always_comb begin
        misaligned = 1'b0;
        case (bus.req_size)
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            2'b11:   misaligned = |bus.req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Lane logic works on the latched offset/size so request inputs may change while busy.
    assign shamt     = {off_q, 3'b000};
    assign lane_mask = size_mask(size_q) << shamt;
    assign merged    = (bus.mem_dout & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    assign shifted   = bus.mem_dout >> shamt;
    assign extended  = extend(shifted, size_q, uns_q);

    always_comb begin
        state_nxt = state;
        we_nxt    = we_q;
        size_nxt  = size_q;
        uns_nxt   = uns_q;
        off_nxt   = off_q;
        wdata_nxt = wdata_q;
        cnt_nxt   = cnt_q;
        rv_nxt    = 1'b0;
        rdata_nxt = 64'd0;
        err_nxt   = 1'b0;
        addr_nxt  = addr_q;
        mwe_nxt   = 1'b0;
        din_nxt   = din_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    we_nxt    = bus.req_we;
                    size_nxt  = bus.req_size;
                    uns_nxt   = bus.req_unsigned;
                    off_nxt   = bus.req_addr[2:0];
                    wdata_nxt = bus.req_wdata;
                    if (misaligned) begin
                        state_nxt = RESP;
                        rv_nxt    = 1'b1;
                        err_nxt   = 1'b1;
                    end else begin
                        addr_nxt = bus.req_addr[ADDR_W+2:3];
                        if (bus.req_we && bus.req_size == 2'b11) begin
                            state_nxt = WRITE;
                            mwe_nxt   = 1'b1;
                            din_nxt   = bus.req_wdata;
                        end else begin
                            state_nxt = RD_WAIT;
                            cnt_nxt   = CNT_W'(READ_LAT - 1);
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        state_nxt = WRITE;
                        mwe_nxt   = 1'b1;
                        din_nxt   = merged;
                    end else begin
                        state_nxt = RESP;
                        rv_nxt    = 1'b1;
                        rdata_nxt = extended;
                    end
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                state_nxt = RESP;
                rv_nxt    = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            off_q   <= 3'd0;
            wdata_q <= 64'd0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rv_q    <= 1'b0;
            rdata_q <= 64'd0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            mwe_q   <= 1'b0;
            din_q   <= 64'd0;
        end else begin
            we_q    <= we_nxt;
            size_q  <= size_nxt;
            uns_q   <= uns_nxt;
            off_q   <= off_nxt;
            wdata_q <= wdata_nxt;
            cnt_q   <= cnt_nxt;
            ready_q <= ready_nxt;
            rv_q    <= rv_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            addr_q  <= addr_nxt;
            mwe_q   <= mwe_nxt;
            din_q   <= din_nxt;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.resp_valid  = rv_q;
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_WE      = mwe_q;
    assign bus.mem_dIn     = din_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   we_cnt = 0;
    int   rv_cnt = 0;
    logic [63:0] mem [32];

    mem_access_unit_if #(.ADDR_W(5)) bus ();

    mem_access_unit #(.ADDR_W(5), .READ_LAT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_WE) mem[bus.mem_address] <= bus.mem_dIn;
    end
    assign bus.mem_dout = mem[bus.mem_address];

    always @(negedge clk) begin
        if (bus.mem_WE === 1'b1) we_cnt <= we_cnt + 1;
        if (bus.resp_valid === 1'b1) rv_cnt <= rv_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [7:0] a, input logic [1:0] sz,
                         input logic u, input logic [63:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = a;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_wdata    = wd;
    endtask

    task automatic do_load(input string tag, input logic [7:0] a, input logic [1:0] sz,
                           input logic u, input logic [63:0] exp);
        int w0;
        w0 = we_cnt;
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        drive(1'b0, a, sz, u, 64'd0);
        step();
        bus.req_valid = 1'b0;
        chk({tag, "_rv_t1"}, 64'(bus.resp_valid), 64'd0);
        step();
        chk({tag, "_rv_t2"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, "_rdata"}, bus.resp_rdata, exp);
        chk({tag, "_err"}, 64'(bus.resp_err), 64'd0);
        step();
        chk({tag, "_rv_t3"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, "_rdata_clr"}, bus.resp_rdata, 64'd0);
        chk({tag, "_nowe"}, 64'(we_cnt - w0), 64'd0);
    endtask

    task automatic do_mis(input string tag, input logic we, input logic [7:0] a,
                          input logic [1:0] sz);
        int w0;
        w0 = we_cnt;
        drive(we, a, sz, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        bus.req_valid = 1'b0;
        chk({tag, "_rv"}, 64'(bus.resp_valid), 64'd1);
        chk({tag, "_err"}, 64'(bus.resp_err), 64'd1);
        chk({tag, "_rdata"}, bus.resp_rdata, 64'd0);
        chk({tag, "_addr"}, 64'(bus.mem_address), 64'd2);
        step();
        chk({tag, "_err_clr"}, 64'(bus.resp_err), 64'd0);
        chk({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
        chk({tag, "_nowe"}, 64'(we_cnt - w0), 64'd0);
    endtask

    initial begin
        int w0;
        int r0;
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 8'd0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 64'd0;

        // reset state and first-cycle readiness
        step();
        step();
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rv", 64'(bus.resp_valid), 64'd0);
        chk("rst_rdata", bus.resp_rdata, 64'd0);
        chk("rst_err", 64'(bus.resp_err), 64'd0);
        chk("rst_addr", 64'(bus.mem_address), 64'd0);
        chk("rst_we", 64'(bus.mem_WE), 64'd0);
        chk("rst_din", bus.mem_dIn, 64'd0);
        reset = 1'b0;
        chk("rel_ready_c0", 64'(bus.req_ready), 64'd0);
        step();
        chk("rel_ready_c1", 64'(bus.req_ready), 64'd1);

        // SD 0x10
        w0 = we_cnt;
        drive(1'b1, 8'h10, 2'b11, 1'b0, 64'h8877_6655_4433_2211);
        step();
        bus.req_valid = 1'b0;
        chk("sd_addr", 64'(bus.mem_address), 64'd2);
        chk("sd_we_t1", 64'(bus.mem_WE), 64'd1);
        chk("sd_din", bus.mem_dIn, 64'h8877_6655_4433_2211);
        chk("sd_rv_t1", 64'(bus.resp_valid), 64'd0);
        chk("sd_ready_t1", 64'(bus.req_ready), 64'd0);
        step();
        chk("sd_we_t2", 64'(bus.mem_WE), 64'd0);
        chk("sd_rv_t2", 64'(bus.resp_valid), 64'd1);
        chk("sd_err", 64'(bus.resp_err), 64'd0);
        chk("sd_rdata", bus.resp_rdata, 64'd0);
        step();
        chk("sd_rv_t3", 64'(bus.resp_valid), 64'd0);
        chk("sd_ready_t3", 64'(bus.req_ready), 64'd1);
        chk("sd_we_count", 64'(we_cnt - w0), 64'd1);
        chk("sd_mem2", mem[2], 64'h8877_6655_4433_2211);

        // loads with extension
        do_load("lb",  8'h17, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF88);
        do_load("lbu", 8'h17, 2'b00, 1'b1, 64'h0000_0000_0000_0088);
        do_load("lh",  8'h12, 2'b01, 1'b0, 64'h0000_0000_0000_4433);
        do_load("lw",  8'h14, 2'b10, 1'b0, 64'hFFFF_FFFF_8877_6655);
        do_load("ld",  8'h10, 2'b11, 1'b0, 64'h8877_6655_4433_2211);

        // SB 0x13 read-modify-write
        w0 = we_cnt;
        drive(1'b1, 8'h13, 2'b00, 1'b0, 64'h0000_0000_0000_00AB);
        step();
        bus.req_valid = 1'b0;
        chk("sb_we_t1", 64'(bus.mem_WE), 64'd0);
        step();
        chk("sb_we_t2", 64'(bus.mem_WE), 64'd1);
        chk("sb_din", bus.mem_dIn, 64'h8877_6655_AB33_2211);
        chk("sb_rv_t2", 64'(bus.resp_valid), 64'd0);
        step();
        chk("sb_we_t3", 64'(bus.mem_WE), 64'd0);
        chk("sb_rv_t3", 64'(bus.resp_valid), 64'd1);
        step();
        chk("sb_we_count", 64'(we_cnt - w0), 64'd1);
        do_load("sb_rb", 8'h10, 2'b11, 1'b0, 64'h8877_6655_AB33_2211);

        // misaligned requests
        do_mis("mis_lw", 1'b0, 8'h12, 2'b10);
        do_mis("mis_sh", 1'b1, 8'h11, 2'b01);

        // reset during RD_WAIT of SH 0x14
        w0 = we_cnt;
        r0 = rv_cnt;
        drive(1'b1, 8'h14, 2'b01, 1'b0, 64'h0000_0000_0000_BEEF);
        step();
        bus.req_valid = 1'b0;
        reset = 1'b1;
        step();
        chk("abort_we", 64'(bus.mem_WE), 64'd0);
        chk("abort_rv", 64'(bus.resp_valid), 64'd0);
        chk("abort_ready", 64'(bus.req_ready), 64'd0);
        step();
        reset = 1'b0;
        chk("abort_ready_c0", 64'(bus.req_ready), 64'd0);
        step();
        chk("abort_ready_c1", 64'(bus.req_ready), 64'd1);
        chk("abort_we_count", 64'(we_cnt - w0), 64'd0);
        chk("abort_rv_count", 64'(rv_cnt - r0), 64'd0);
        chk("abort_mem2", mem[2], 64'h8877_6655_AB33_2211);

        // back-to-back with req_valid held high
        r0 = rv_cnt;
        drive(1'b0, 8'h10, 2'b11, 1'b0, 64'd0);
        step();
        chk("b2b_ready_t1", 64'(bus.req_ready), 64'd0);
        drive(1'b1, 8'h08, 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF);
        step();
        chk("b2b_rv1", 64'(bus.resp_valid), 64'd1);
        chk("b2b_rdata1", bus.resp_rdata, 64'h8877_6655_AB33_2211);
        chk("b2b_ready_t2", 64'(bus.req_ready), 64'd0);
        chk("b2b_we_t2", 64'(bus.mem_WE), 64'd0);
        step();
        chk("b2b_ready_t3", 64'(bus.req_ready), 64'd1);
        chk("b2b_rv_t3", 64'(bus.resp_valid), 64'd0);
        step();
        bus.req_valid = 1'b0;
        chk("b2b_ready_t4", 64'(bus.req_ready), 64'd0);
        chk("b2b_we_t4", 64'(bus.mem_WE), 64'd1);
        chk("b2b_addr_t4", 64'(bus.mem_address), 64'd1);
        step();
        chk("b2b_rv2", 64'(bus.resp_valid), 64'd1);
        step();
        chk("b2b_ready_t6", 64'(bus.req_ready), 64'd1);
        step();
        chk("b2b_rv_count", 64'(rv_cnt - r0), 64'd2);
        chk("b2b_mem1", mem[1], 64'h0123_4567_89AB_CDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: accepts load/store requests from the core datapath and drives the doubleword-wide data memory (address, write-enable, write data), capturing its read data.
- Implements RISC-V byte/half/word/double loads with sign or zero extension.
- Partial-width stores use read-modify-write, because the memory only writes full 64-bit words.
- Sits between the execute/memory stage and the data memory; instruction fetch is out of scope.

Parameters:
- ADDR_W, 5: doubleword index width (32 x 64-bit words).
- READ_LAT, 1: cycles from address issue to mem_dout sampling. Must be >=1; 1 means mem_dout is sampled at the end of the first wait cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted when req_valid and req_ready are both high at a clk edge.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W+3  byte address.
- req_size  in  2  00 = B, 01 = H, 10 = W, 11 = D.
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned request; valid with resp_valid.
- mem_address  out  ADDR_W  doubleword index, req_addr[ADDR_W+2:3].
- mem_WE  out  1  memory write enable.
- mem_dIn  out  64  memory write data.
- mem_dout  in  64  memory read data.

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high.
  - While reset is sampled high: state IDLE; all outputs 0, including req_ready.
  - req_ready is 1 from the first cycle after reset deasserts.
- Outputs: all outputs are registered.
- Handshake:
  - req_ready is high only in IDLE.
  - Request inputs are latched on acceptance and may change afterwards.
  - No response backpressure.
  - The next request can be accepted no earlier than the cycle after resp_valid.
- Alignment: offset = req_addr[2:0]. Misaligned when:
  - H: offset[0] != 0
  - W: offset[1:0] != 0
  - D: offset != 0
- Byte lanes: little-endian; byte k = bits [8k+7:8k].
- States: IDLE, RD_WAIT, WRITE, RESP.
- From IDLE, on acceptance at the edge ending cycle T:
  - Misaligned -> RESP. resp_err=1, resp_rdata=0, mem_* untouched, resp_valid at T+1.
  - Load, or store with size != D -> RD_WAIT.
    - mem_address driven from T+1.
    - A counter runs READ_LAT cycles; mem_dout is sampled at the end of cycle T+READ_LAT.
  - Store with size D -> WRITE.
    - mem_WE=1, mem_dIn=req_wdata during T+1.
    - resp_valid at T+2.
- From RD_WAIT:
  - Load -> RESP. resp_rdata = selected lanes, extended per req_unsigned. resp_valid at T+READ_LAT+1.
  - Partial store -> WRITE. mem_dIn = sampled word with the addressed lanes replaced by the low bytes of req_wdata; other lanes unchanged.
    - mem_WE=1 during T+READ_LAT+1.
    - resp_valid at T+READ_LAT+2.
- mem_WE: high for exactly one cycle per store, only in WRITE.
- mem_address holds its last value when idle.
- RESP: resp_valid=1 for one cycle, then IDLE. resp_rdata/resp_err return to 0 in the following cycle.
- Reset mid-operation: abort at that edge.
  - mem_WE is 0 in the next cycle.
  - No resp_valid is issued for the aborted request; memory is not written if reset precedes WRITE.
- Simultaneous: req_valid during reset is ignored; req_valid while busy is not accepted (req_ready=0).

Test Plan:
Bench memory: 32x64 array, written on clk when mem_WE, combinational read, READ_LAT=1.
1. Reset 2 cycles -> all outputs 0; req_ready=1 the cycle after release. Then SD addr 0x10, wdata 0x8877665544332211 accepted at T -> mem_address=2, mem_WE=1 only at T+1, resp_valid at T+2, resp_err=0, mem[2]=0x8877665544332211.
2. With mem[2]=0x8877665544332211:
   - LB 0x17 -> 0xFFFFFFFFFFFFFF88
   - LBU 0x17 -> 0x0000000000000088
   - LH 0x12 -> 0x0000000000004433
   - LW 0x14 -> 0xFFFFFFFF88776655
   - LD 0x10 -> 0x8877665544332211
   - Each: resp_valid at T+2, mem_WE never 1.
3. SB 0x13, wdata 0xAB -> mem_WE=1 at T+2 only, mem_dIn=0x88776655AB332211; resp_valid at T+3; readback LD 0x10 matches.
4. Misaligned LW 0x12 and SH 0x11 -> resp_valid at T+1, resp_err=1, resp_rdata=0, mem_WE stays 0, mem_address unchanged.
5. SH 0x14, reset asserted during RD_WAIT -> mem_WE never 1, no resp_valid, mem[2] unchanged; req_ready=1 one cycle after reset release.
6. req_valid held high with LD 0x10 then SD 0x08 -> req_ready=0 from T+1 until the cycle after the first resp_valid; second request accepted only then; exactly two resp_valid pulses.
